// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter that grants NUM_CORES cores one at a time onto a single
// synchronous single-port data RAM, returning per-core ack pulses, stalls and held read data.
module dram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_addr,
  input  logic [NUM_CORES*2-1:0]      i_core_read,
  input  logic [NUM_CORES*2-1:0]      i_core_write,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_wdata,
  output logic [NUM_CORES*DATA_W-1:0] o_core_rdata,
  output logic [NUM_CORES-1:0]        o_ack,
  output logic [NUM_CORES-1:0]        o_stall,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic                        o_mem_we,
  output logic [DATA_W-1:0]           o_mem_wdata,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_busy
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]                  r_state;
  logic [IDX_W-1:0]            r_ptr;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_is_wr;
  logic                        r_mask;
  logic [NUM_CORES*DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0]           r_mem_addr;
  logic [DATA_W-1:0]           r_mem_wdata;
  logic                        r_mem_we;
  logic [NUM_CORES-1:0]        w_req;
  logic [NUM_CORES-1:0]        w_wr;
  logic [NUM_CORES-1:0]        w_elig;
  logic                        w_found;
  logic [IDX_W-1:0]            w_win;
  logic [IDX_W-1:0]            w_j;

  always_comb begin
    w_req = '0;
    w_wr  = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      w_wr[n]  = |i_core_write[n*2 +: 2];
      w_req[n] = (|i_core_write[n*2 +: 2]) | (|i_core_read[n*2 +: 2]);
    end
  end

  // the core acked last cycle is still dropping its request, so ignore it once
  assign w_elig = w_req & ~(r_mask ? (NUM_CORES'(1) << r_ptr) : '0);

  // walk offsets high to low so the nearest requester after r_ptr wins
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_j     = r_ptr;
    for (int i = NUM_CORES; i >= 1; i--) begin
      w_j = IDX_W'((int'(r_ptr) + i) % NUM_CORES);
      if (w_elig[w_j]) begin
        w_found = 1'b1;
        w_win   = w_j;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_CORES - 1);
      r_idx       <= '0;
      r_is_wr     <= 1'b0;
      r_mask      <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_mask <= 1'b0;
          if (w_found) begin
            r_state    <= S_GRANT;
            r_idx      <= w_win;
            r_is_wr    <= w_wr[w_win];
            r_mem_addr <= i_core_addr[w_win*ADDR_W +: ADDR_W];
            if (w_wr[w_win]) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= i_core_wdata[w_win*DATA_W +: DATA_W];
            end
          end
        end
        S_GRANT:  r_state <= r_is_wr ? S_ACK : S_RDWAIT;
        S_RDWAIT: begin
          r_rdata[r_idx*DATA_W +: DATA_W] <= i_mem_rdata;
          r_state                         <= S_ACK;
        end
        default: begin
          r_ptr   <= r_idx;
          r_mask  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack        = (r_state == S_ACK) ? (NUM_CORES'(1) << r_idx) : '0;
  assign o_stall      = w_req & ~o_ack;
  assign o_core_rdata = r_rdata;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_we     = r_mem_we;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed vector table, multi-cycle corner sequences and a randomized
// run against a transaction-timeline model of the arbiter with a behavioural RAM.
module tb_dram_arbiter;
  localparam int N = 4;

  typedef struct {
    int         core;
    logic [1:0] rd;
    logic [1:0] wr;
    logic [15:0] addr;
    logic [7:0] wdata;
    bit         is_wr;
    logic [7:0] exp_rd;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*16-1:0] core_addr = '0;
  logic [N*2-1:0]  core_read = '0;
  logic [N*2-1:0]  core_write = '0;
  logic [N*8-1:0]  core_wdata = '0;
  logic [N*8-1:0]  core_rdata;
  logic [N-1:0]    ack;
  logic [N-1:0]    stall;
  logic [15:0]     mem_addr;
  logic            mem_we;
  logic [7:0]      mem_wdata;
  logic [7:0]      mem_rdata;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_rd [N];
  logic [7:0] mm [logic [15:0]];
  vec_t tbl [7];

  dram_arbiter #(.NUM_CORES(N), .ADDR_W(16), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_addr(core_addr), .i_core_read(core_read), .i_core_write(core_write),
    .i_core_wdata(core_wdata), .o_core_rdata(core_rdata), .o_ack(ack), .o_stall(stall),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // unwritten RAM locations read back a fixed function of their address
  function automatic logic [7:0] f_init(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7C;
  endfunction

  logic [7:0]     ram [0:65535];
  logic [65535:0] ram_vld;
  always @(posedge clk) begin
    if (!rst_n) ram_vld <= '0;
    else if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      ram_vld[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : f_init(mem_addr);
  end

  function automatic logic [7:0] mm_rd(input logic [15:0] a);
    return mm.exists(a) ? mm[a] : f_init(a);
  endfunction

  function automatic logic [N*8-1:0] pack_rd();
    logic [N*8-1:0] p;
    for (int n = 0; n < N; n++) p[n*8 +: 8] = exp_rd[n];
    return p;
  endfunction

  function automatic logic [N-1:0] cur_req();
    logic [N-1:0] r;
    for (int n = 0; n < N; n++) r[n] = (core_read[n*2 +: 2] != 2'd0) || (core_write[n*2 +: 2] != 2'd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic set_core(input int n, input logic [1:0] rd, input logic [1:0] wr,
                          input logic [15:0] a, input logic [7:0] d);
    core_read[n*2 +: 2]   = rd;
    core_write[n*2 +: 2]  = wr;
    core_addr[n*16 +: 16] = a;
    core_wdata[n*8 +: 8]  = d;
  endtask

  task automatic clr_core(input int n);
    core_read[n*2 +: 2]  = 2'd0;
    core_write[n*2 +: 2] = 2'd0;
  endtask

  task automatic new_req(input int n);
    int ty;
    ty = $urandom_range(0, 2);
    set_core(n, (ty == 1) ? 2'd0 : 2'($urandom_range(1, 3)), (ty == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
             16'h0500 + 16'($urandom_range(0, 15)), 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    core_read  = '0;
    core_write = '0;
    for (int n = 0; n < N; n++) exp_rd[n] = 8'h00;
    mm.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int lat, m_last, m_last_ack, m_arb, m_cur, m_lat, w, j;
    bit m_busy, m_wr, found, e_busy;
    logic [15:0] m_addr;
    logic [7:0] m_wd;
    logic [N-1:0] e_ack, req, elig, ack_prev, pend;
    logic [N-1:0] exp_c [13];
    logic         we_c [13];

    tbl[0] = '{2, 2'd0, 2'd1, 16'h0123, 8'hA5, 1'b1, 8'h00};
    tbl[1] = '{1, 2'd1, 2'd0, 16'h0040, 8'h00, 1'b0, 8'h3C};
    tbl[2] = '{3, 2'd2, 2'd3, 16'h0200, 8'h77, 1'b1, 8'h00};
    tbl[3] = '{0, 2'd3, 2'd0, 16'h0123, 8'hEE, 1'b0, 8'hA5};
    tbl[4] = '{3, 2'd1, 2'd0, 16'h0200, 8'h00, 1'b0, 8'h77};
    tbl[5] = '{1, 2'd0, 2'd2, 16'hFFFF, 8'hC3, 1'b1, 8'h00};
    tbl[6] = '{2, 2'd2, 2'd0, 16'hFFFF, 8'h00, 1'b0, 8'hC3};

    do_reset();
    to_check;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_stall", stall, 0);
    to_drive;

    foreach (tbl[r]) begin
      v   = tbl[r];
      lat = v.is_wr ? 2 : 3;
      set_core(v.core, v.rd, v.wr, v.addr, v.wdata);
      if (!v.is_wr) exp_rd[v.core] = v.exp_rd;
      for (int k = 0; k <= lat; k++) begin
        to_check;
        if (k == 0) begin
          chk($sformatf("tbl%0d_stall_req", r), stall[v.core], 1);
          chk($sformatf("tbl%0d_idle_busy", r), busy, 0);
        end
        if (k == 1) begin
          chk($sformatf("tbl%0d_addr", r), mem_addr, v.addr);
          chk($sformatf("tbl%0d_we", r), mem_we, v.is_wr);
          if (v.is_wr) chk($sformatf("tbl%0d_wdata", r), mem_wdata, v.wdata);
        end
        chk($sformatf("tbl%0d_ack_k%0d", r, k), ack, (k == lat) ? (4'(1) << v.core) : 4'(0));
        if (k == lat) begin
          chk($sformatf("tbl%0d_rdata", r), core_rdata, pack_rd());
          chk($sformatf("tbl%0d_stall_ack", r), stall[v.core], 0);
        end
        to_drive;
      end
      clr_core(v.core);
      to_check;
      chk($sformatf("tbl%0d_after_busy", r), busy, 0);
      to_drive;
    end

    // all four cores read at once from reset: served 0,1,2,3, four cycles apart
    do_reset();
    for (int n = 0; n < N; n++) set_core(n, 2'd1, 2'd0, 16'h0010 + 16'(n), 8'h00);
    pend = 4'hF;
    for (int k = 0; k < 16; k++) begin
      to_check;
      e_ack = (k % 4 == 3) ? (4'(1) << (k / 4)) : 4'(0);
      if (e_ack != 0) exp_rd[k / 4] = 8'h6C + 8'(k / 4);
      chk($sformatf("rr_ack_k%0d", k), ack, e_ack);
      chk($sformatf("rr_stall_k%0d", k), stall, pend & ~e_ack);
      chk($sformatf("rr_rdata_k%0d", k), core_rdata, pack_rd());
      to_drive;
      if (e_ack != 0) begin
        clr_core(k / 4);
        pend = pend & ~e_ack;
      end
    end

    // core 0 keeps requesting through its ack; the cycle after each ack ignores it
    exp_c = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
    we_c  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    set_core(0, 2'd0, 2'd1, 16'h0300, 8'h11);
    set_core(1, 2'd0, 2'd1, 16'h0301, 8'h22);
    for (int k = 0; k < 13; k++) begin
      to_check;
      chk($sformatf("mask_ack_k%0d", k), ack, exp_c[k]);
      chk($sformatf("mask_we_k%0d", k), mem_we, we_c[k]);
      if (k == 1) chk("mask_addr0", mem_addr, 16'h0300);
      if (k == 4) chk("mask_addr1", mem_addr, 16'h0301);
      to_drive;
      if (k == 5) clr_core(1);
      if (k == 12) clr_core(0);
    end

    // asynchronous reset while a read waits on RAM data
    set_core(2, 2'd1, 2'd0, 16'h0040, 8'h00);
    to_check;
    chk("rsta_stall", stall, 4'b0100);
    to_drive;
    to_check;
    chk("rsta_grant_addr", mem_addr, 16'h0040);
    to_drive;
    to_check;
    chk("rsta_rdwait_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rsta_busy", busy, 0);
    chk("rsta_ack", ack, 0);
    chk("rsta_we", mem_we, 0);
    chk("rsta_addr", mem_addr, 0);
    chk("rsta_wdata", mem_wdata, 0);
    chk("rsta_rdata", core_rdata, 0);
    for (int n = 0; n < N; n++) exp_rd[n] = 8'h00;
    mm.delete();
    repeat (2) begin
      @(negedge clk);
      chk("rsta_noack", ack, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      to_check;
      chk($sformatf("rsta_again_ack_k%0d", k), ack, (k == 3) ? 4'b0100 : 4'b0000);
      if (k == 3) begin
        exp_rd[2] = 8'h3C;
        chk("rsta_again_rdata", core_rdata, pack_rd());
      end
      to_drive;
    end
    clr_core(2);

    // randomized traffic against a timeline model built from the latency rules
    do_reset();
    m_last     = N - 1;
    m_last_ack = -10;
    m_busy     = 1'b0;
    m_arb      = 0;
    m_cur      = 0;
    m_lat      = 0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_wd       = '0;
    ack_prev   = '0;
    for (int c = 0; c < 3000; c++) begin
      req = cur_req();
      for (int n = 0; n < N; n++) begin
        if (req[n] && ack_prev[n]) begin
          if ($urandom_range(0, 3) == 0) new_req(n);
          else clr_core(n);
        end else if (req[n] && $urandom_range(0, 7) == 0) begin
          core_addr[n*16 +: 16] = 16'h0500 + 16'($urandom_range(0, 15));
          core_wdata[n*8 +: 8]  = 8'($urandom);
        end else if (!req[n] && $urandom_range(0, 2) == 0) new_req(n);
      end
      to_check;
      req    = cur_req();
      e_ack  = '0;
      e_busy = m_busy && (c > m_arb);
      if (m_busy && c == m_arb + 1) begin
        chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_we", mem_we, m_wr);
        if (m_wr) chk("rnd_wdata", mem_wdata, m_wd);
      end else chk("rnd_we_idle", mem_we, 0);
      if (m_busy && c == m_arb + m_lat) begin
        e_ack = 4'(1) << m_cur;
        if (m_wr) mm[m_addr] = m_wd;
        else exp_rd[m_cur] = mm_rd(m_addr);
        m_busy     = 1'b0;
        m_last     = m_cur;
        m_last_ack = c;
      end else if (!m_busy) begin
        elig  = req & ~((c == m_last_ack + 1) ? (4'(1) << m_last) : 4'(0));
        found = 1'b0;
        w     = 0;
        for (int i = 1; i <= N; i++) begin
          j = (m_last + i) % N;
          if (!found && elig[j[1:0]]) begin
            found = 1'b1;
            w     = j;
          end
        end
        if (found) begin
          m_busy = 1'b1;
          m_arb  = c;
          m_cur  = w;
          m_wr   = core_write[w*2 +: 2] != 2'd0;
          m_lat  = m_wr ? 2 : 3;
          m_addr = core_addr[w*16 +: 16];
          m_wd   = core_wdata[w*8 +: 8];
        end
      end
      chk("rnd_ack", ack, e_ack);
      chk("rnd_stall", stall, req & ~e_ack);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_rdata", core_rdata, pack_rd());
      ack_prev = ack;
      to_drive;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
